// File: rtl/tensor_core_param.sv
// rtl/tensor_core_param.sv - parametrised BF16 output-stationary DIMxDIM tensor core
// D = A*B(+C) or A*B^T+C, one k-step per cycle, ready/valid on both sides.
module tensor_core_param #(
    parameter int DIM = 4,
    parameter int DW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op_mode,
    input  logic [DIM*DIM*DW-1:0] matrix_a,
    input  logic [DIM*DIM*DW-1:0] matrix_b,
    input  logic [DIM*DIM*DW-1:0] matrix_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIM*DIM*DW-1:0] matrix_d,
    output logic                  busy
);
    localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [15:0] QNAN = 16'h7FC0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_t;

    function automatic logic is_nan(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'h0);
    endfunction

    function automatic logic is_inf(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] == 7'h0);
    endfunction

    function automatic logic is_zero(input logic [15:0] v);
        return v[14:7] == 8'h00;
    endfunction

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [15:0] p;
        logic [8:0]  m;
        logic        g;
        logic        st;
        logic [15:0] r;
        int          e;
        s = a[15] ^ b[15];
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            m = {2'b01, p[14:8]}; g = p[7]; st = |p[6:0]; e = e + 1;
        end else begin
            m = {2'b01, p[13:7]}; g = p[6]; st = |p[5:0];
        end
        if (g && (st || m[0])) m = m + 9'd1;
        if (m[8]) begin m = m >> 1; e = e + 1; end
        if (e >= 255)    r = {s, 8'hFF, 7'h0};
        else if (e <= 0) r = {s, 15'h0};
        else             r = {s, e[7:0], m[6:0]};
        if (is_nan(a) || is_nan(b))                                 r = QNAN;
        else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) r = QNAN;
        else if (is_inf(a) || is_inf(b))                            r = {s, 8'hFF, 7'h0};
        else if (is_zero(a) || is_zero(b))                          r = {s, 15'h0};
        return r;
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, r;
        logic [25:0] sx, sy, sd, mask;
        logic [26:0] sum;
        logic [8:0]  m;
        logic        g, st, sub;
        int          e, d, lz;
        x = a; y = b; r = 16'h0; mask = '0; sd = '0; sum = '0;
        m = '0; g = 1'b0; st = 1'b0; lz = 0;
        if (a[14:0] < b[14:0]) begin x = b; y = a; end
        sx  = {1'b1, x[6:0], 18'h0};
        sy  = {1'b1, y[6:0], 18'h0};
        d   = int'(x[14:7]) - int'(y[14:7]);
        e   = int'(x[14:7]);
        sub = x[15] ^ y[15];
        // Far-away addend only contributes a sticky bit below the rounding point.
        if (d > 25) sd = 26'h1;
        else begin
            mask = (26'h1 << d) - 26'h1;
            sd   = (sy >> d) | {25'h0, |(sy & mask)};
        end
        sum = sub ? ({1'b0, sx} - {1'b0, sd}) : ({1'b0, sx} + {1'b0, sd});
        if (sum[26]) begin
            sum = {1'b0, sum[26:1]} | {26'h0, sum[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 26; i++) if (sum[i]) lz = 25 - i;
            sum = sum << lz;
            e = e - lz;
        end
        m  = {2'b01, sum[24:18]};
        g  = sum[17];
        st = |sum[16:0];
        if (g && (st || m[0])) m = m + 9'd1;
        if (m[8]) begin m = m >> 1; e = e + 1; end
        if (sum == 27'h0)  r = 16'h0;
        else if (e >= 255) r = {x[15], 8'hFF, 7'h0};
        else if (e <= 0)   r = {x[15], 15'h0};
        else               r = {x[15], e[7:0], m[6:0]};
        if (is_nan(a) || is_nan(b))         r = QNAN;
        else if (is_inf(a) && is_inf(b))    r = (a[15] != b[15]) ? QNAN : a;
        else if (is_inf(a))                 r = a;
        else if (is_inf(b))                 r = b;
        else if (is_zero(a) && is_zero(b))  r = {a[15] & b[15], 15'h0};
        else if (is_zero(a))                r = b;
        else if (is_zero(b))                r = a;
        return r;
    endfunction

    state_t                  r_state, w_state_next;
    logic [DIM*DIM*DW-1:0]   r_a, r_b, r_c, r_d;
    logic [1:0]              r_mode;
    logic [KW-1:0]           r_k;
    logic [DW-1:0]           r_acc      [DIM][DIM];
    logic [DW-1:0]           w_acc_next [DIM][DIM];
    logic                    w_accept;
    logic                    w_k_last;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_k_last  = (r_k == KW'(DIM - 1));
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign matrix_d  = r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_MAC;
            S_MAC:   if (w_k_last) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = in_valid ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Broadcast A column k and B row k (or B column k when transposing) to every PE.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                w_acc_next[i][j] = bf16_add(r_acc[i][j], bf16_mul(
                    r_a[(i*DIM + int'(r_k))*DW +: DW],
                    (r_mode == 2'b10) ? r_b[(j*DIM + int'(r_k))*DW +: DW]
                                      : r_b[(int'(r_k)*DIM + j)*DW +: DW]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_mode <= 2'b00;
            r_k    <= '0;
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    r_acc[i][j] <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= matrix_a;
                r_b    <= matrix_b;
                r_c    <= matrix_c;
                r_mode <= op_mode;
            end
            if (r_state == S_LOAD) begin
                r_k <= '0;
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++)
                        r_acc[i][j] <= (r_mode == 2'b01) ? '0 : r_c[(i*DIM + j)*DW +: DW];
            end
            if (r_state == S_MAC) begin
                if (!w_k_last) r_k <= r_k + 1'b1;
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        r_acc[i][j] <= w_acc_next[i][j];
                        if (w_k_last) r_d[(i*DIM + j)*DW +: DW] <= w_acc_next[i][j];
                    end
            end
        end
    end
endmodule
